mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_if.sv | 23 ++
 rtl/mem_responder.sv | 129 ++++++++++++
 tb/tb_mem_responder.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bus of the wait-state memory responder.
// A request is held (req plus fields stable) until ack is seen; ack is a one-cycle pulse.
interface mem_responder_if;
   logic        req;
   logic        DataMemRW;
   logic [31:0] addr;
   logic [31:0] DataIn;
   logic [31:0] DataOut;
   logic        ack;
   logic        err;
   logic        busy;
   logic [1:0]  state;

   modport master (
      output req, DataMemRW, addr, DataIn,
      input  DataOut, ack, err, busy, state
   );

   modport slave (
      input  req, DataMemRW, addr, DataIn,
      output DataOut, ack, err, busy, state
   );
endinterface

// File: rtl/mem_responder.sv
// Word-array memory responder with WAIT wait-states per access, one-cycle ack pulse,
// error flagging for misaligned/out-of-range addresses, and full async clear on reset.
module mem_responder #(
   parameter int DEPTH_LOG2 = 6,
   parameter int WAIT       = 2
) (
   input  logic            click,
   input  logic            reset,
   mem_responder_if.slave  bus
);
   localparam int         DEPTH  = 1 << DEPTH_LOG2;
   localparam logic [2:0] WAIT_W = 3'(WAIT);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAITST = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [2:0]  cnt;
   logic [2:0]  cnt_nxt;

   logic        lat_rw;
   logic [31:0] lat_addr;
   logic [31:0] lat_data;

   logic [31:0] mem [DEPTH];
   logic [31:0] dout;
   logic        resp_err;

   logic                  accept;
   logic                  enter_resp;
   logic                  eff_rw;
   logic [31:0]           eff_addr;
   logic [31:0]           eff_data;
   logic                  eff_err;
   logic [DEPTH_LOG2-1:0] eff_idx;

   // With WAIT=0 RESP is entered on the accept edge itself, so the live inputs
   // stand in for the latched fields on that one edge.
   assign accept   = (state == IDLE) && bus.req;
   assign eff_rw   = accept ? bus.DataMemRW : lat_rw;
   assign eff_addr = accept ? bus.addr      : lat_addr;
   assign eff_data = accept ? bus.DataIn    : lat_data;
   assign eff_idx  = eff_addr[DEPTH_LOG2+1:2];
   assign eff_err  = (eff_addr[1:0] != 2'b00) || (|eff_addr[31:DEPTH_LOG2+2]);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (bus.req) begin
               if (WAIT_W == 3'd0) begin
                  state_nxt = RESP;
               end else begin
                  state_nxt = WAITST;
                  cnt_nxt   = WAIT_W;
               end
            end
         end
         WAITST: begin
            if (cnt == 3'd1) begin
               state_nxt = RESP;
               cnt_nxt   = 3'd0;
            end else begin
               cnt_nxt = cnt - 3'd1;
            end
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = 3'd0;
         end
      endcase
   end

   assign enter_resp = (state_nxt == RESP);

   always_ff @(posedge click or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= 3'd0;
         lat_rw   <= 1'b0;
         lat_addr <= '0;
         lat_data <= '0;
         dout     <= '0;
         resp_err <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) begin
            lat_rw   <= bus.DataMemRW;
            lat_addr <= bus.addr;
            lat_data <= bus.DataIn;
         end
         if (enter_resp) begin
            resp_err <= eff_err;
            if (eff_err) begin
               dout <= '0;
            end else if (!eff_rw) begin
               dout <= mem[eff_idx];
            end
         end
      end
   end

   // Writes commit only as RESP is entered, so a reset during WAITST loses them.
   always_ff @(posedge click or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (enter_resp && eff_rw && !eff_err) begin
         mem[eff_idx] <= eff_data;
      end
   end

   assign bus.ack     = (state == RESP);
   assign bus.err     = (state == RESP) && resp_err;
   assign bus.busy    = (state != IDLE);
   assign bus.DataOut = dout;
   assign bus.state   = state;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one instance with WAIT=2 (directed + random traffic) and
// one with WAIT=0 (held-req back-to-back), each checked by a queue-based scoreboard.
module tb_mem_responder;
   logic click = 1'b0;
   logic rst_a = 1'b1;
   logic rst_b = 1'b1;

   always #5 click = ~click;

   mem_responder_if bus_a ();
   mem_responder_if bus_b ();

   mem_responder #(.DEPTH_LOG2(6), .WAIT(2)) dut_a (.click(click), .reset(rst_a), .bus(bus_a));
   mem_responder #(.DEPTH_LOG2(6), .WAIT(0)) dut_b (.click(click), .reset(rst_b), .bus(bus_b));

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: word arrays, last returned read data, expected {err, DataOut} queues
   logic [31:0] mem_a [64];
   logic [31:0] mem_b [64];
   logic [31:0] last_a;
   logic [31:0] last_b;
   logic [32:0] exp_a[$];
   logic [32:0] exp_b[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset(input bit sel);
      for (int i = 0; i < 64; i++) begin
         if (sel) mem_b[i] = '0;
         else     mem_a[i] = '0;
      end
      if (sel) begin
         last_b = '0;
         exp_b.delete();
      end else begin
         last_a = '0;
         exp_a.delete();
      end
   endtask

   task automatic model_issue(input bit sel, input logic rw, input logic [31:0] a, input logic [31:0] d);
      bit          bad;
      int          idx;
      logic [31:0] last;
      bad  = ((a % 4) != 0) || (a >= 32'd256);
      idx  = int'(a / 4);
      last = sel ? last_b : last_a;
      if (bad) begin
         last = '0;
         if (sel) exp_b.push_back({1'b1, 32'h0});
         else     exp_a.push_back({1'b1, 32'h0});
      end else if (rw) begin
         if (sel) begin
            exp_b.push_back({1'b0, last});
            mem_b[idx] = d;
         end else begin
            exp_a.push_back({1'b0, last});
            mem_a[idx] = d;
         end
      end else begin
         last = sel ? mem_b[idx] : mem_a[idx];
         if (sel) exp_b.push_back({1'b0, last});
         else     exp_a.push_back({1'b0, last});
      end
      if (sel) last_b = last;
      else     last_a = last;
   endtask

   // Monitors: pop one expectation per ack; err must be low outside ack
   always @(negedge click) begin
      logic [32:0] e;
      if (bus_a.ack) begin
         if (exp_a.size() == 0) begin
            check("a_unexpected_ack", 64'(bus_a.ack), 64'd0);
         end else begin
            e = exp_a.pop_front();
            check("a_resp", 64'({bus_a.err, bus_a.DataOut}), 64'(e));
         end
      end else begin
         check("a_err_without_ack", 64'(bus_a.err), 64'd0);
      end
   end

   always @(negedge click) begin
      logic [32:0] e;
      if (bus_b.ack) begin
         if (exp_b.size() == 0) begin
            check("b_unexpected_ack", 64'(bus_b.ack), 64'd0);
         end else begin
            e = exp_b.pop_front();
            check("b_resp", 64'({bus_b.err, bus_b.DataOut}), 64'(e));
         end
      end else begin
         check("b_err_without_ack", 64'(bus_b.err), 64'd0);
      end
   end

   task automatic xfer_a(input logic rw, input logic [31:0] a, input logic [31:0] d, input bit scramble);
      int waits;
      bit done;
      @(negedge click);
      bus_a.req       = 1'b1;
      bus_a.DataMemRW = rw;
      bus_a.addr      = a;
      bus_a.DataIn    = d;
      model_issue(1'b0, rw, a, d);
      @(posedge click);
      waits = 0;
      done  = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         @(negedge click);
         if (c == 0) check("a_busy_after_accept", 64'(bus_a.busy), 64'd1);
         if (bus_a.ack) begin
            done = 1'b1;
         end else begin
            waits++;
            if (scramble) begin
               bus_a.addr      = $urandom;
               bus_a.DataIn    = $urandom;
               bus_a.DataMemRW = 1'($urandom_range(0, 1));
            end
         end
      end
      check("a_ack_seen", 64'(done), 64'd1);
      check("a_wait_cycles", 64'(waits), 64'd2);
      bus_a.req = 1'b0;
      @(negedge click);
      check("a_idle_after_resp", 64'({bus_a.busy, bus_a.ack}), 64'd0);
   endtask

   initial begin
      #20_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          ack_cycles[$];
      int          r;
      logic [31:0] a;
      logic        rw;

      bus_a.req = 1'b0; bus_a.DataMemRW = 1'b0; bus_a.addr = '0; bus_a.DataIn = '0;
      bus_b.req = 1'b0; bus_b.DataMemRW = 1'b0; bus_b.addr = '0; bus_b.DataIn = '0;
      model_reset(1'b0);
      model_reset(1'b1);

      #12;
      check("a_reset_outputs", 64'({bus_a.busy, bus_a.ack, bus_a.err, bus_a.DataOut}), 64'd0);
      check("b_reset_outputs", 64'({bus_b.busy, bus_b.ack, bus_b.err, bus_b.DataOut}), 64'd0);
      @(negedge click);
      rst_a = 1'b0;
      rst_b = 1'b0;

      // Directed accesses on the WAIT=2 instance
      xfer_a(1'b1, 32'h10,  32'h12345678, 1'b0);
      xfer_a(1'b0, 32'h10,  32'h0,        1'b0);
      xfer_a(1'b0, 32'h14,  32'h0,        1'b0);
      xfer_a(1'b1, 32'h11,  32'hCAFEF00D, 1'b0);
      xfer_a(1'b0, 32'h10,  32'h0,        1'b0);
      xfer_a(1'b0, 32'h100, 32'h0,        1'b0);

      // Reset one cycle into a write: no ack, busy drops at once, memory cleared
      @(negedge click);
      bus_a.req = 1'b1; bus_a.DataMemRW = 1'b1; bus_a.addr = 32'h20; bus_a.DataIn = 32'hDEADBEEF;
      @(posedge click);
      @(negedge click);
      bus_a.req = 1'b0;
      @(posedge click);
      #1 rst_a = 1'b1;
      #1;
      check("a_abort_outputs", 64'({bus_a.busy, bus_a.ack, bus_a.err, bus_a.DataOut}), 64'd0);
      model_reset(1'b0);
      repeat (2) @(negedge click);
      rst_a = 1'b0;
      xfer_a(1'b0, 32'h20, 32'h0, 1'b0);

      // Held req across two transfers on the WAIT=0 instance
      @(negedge click);
      bus_b.req = 1'b1; bus_b.DataMemRW = 1'b1; bus_b.addr = 32'h04; bus_b.DataIn = 32'hA5A5A5A5;
      model_issue(1'b1, 1'b1, 32'h04, 32'hA5A5A5A5);
      for (int c = 0; c < 10; c++) begin
         @(negedge click);
         if (c == 0) check("b_busy_after_accept", 64'(bus_b.busy), 64'd1);
         if (bus_b.ack) begin
            ack_cycles.push_back(c);
            if (ack_cycles.size() == 1) begin
               bus_b.DataMemRW = 1'b0;
               bus_b.DataIn    = $urandom;
               model_issue(1'b1, 1'b0, 32'h04, 32'h0);
            end else begin
               bus_b.req = 1'b0;
            end
         end
      end
      bus_b.req = 1'b0;
      check("b_ack_count", 64'(ack_cycles.size()), 64'd2);
      if (ack_cycles.size() >= 2)
         check("b_ack_spacing", 64'(ack_cycles[1] - ack_cycles[0]), 64'd2);

      // Random traffic with input scrambling after acceptance
      for (int t = 0; t < 150; t++) begin
         r  = int'($urandom_range(0, 9));
         rw = 1'($urandom_range(0, 1));
         if (r < 6)      a = 32'($urandom_range(0, 15)) * 4;
         else if (r < 8) a = 32'($urandom_range(0, 63)) * 4;
         else if (r < 9) a = 32'($urandom_range(0, 63)) * 4 + 32'($urandom_range(1, 3));
         else            a = $urandom | 32'h100;
         xfer_a(rw, a, $urandom, 1'b1);
         repeat ($urandom_range(0, 2)) @(negedge click);
      end

      repeat (4) @(negedge click);
      check("a_queue_drained", 64'(exp_a.size()), 64'd0);
      check("b_queue_drained", 64'(exp_b.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
